// File: rtl/exu_stage.sv
// Execute stage: holds one decoded instruction, runs the ALU,
// resolves branches/jumps into a one-cycle redirect, feeds the LSU.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          drop the held instruction
//   in_*           decoded instruction from the decoder (valid/ready)
//   out_*          result, store data and control to the LSU (valid/ready)
//   redirect_*     taken branch/jump target, valid on the firing cycle

module exu_alu #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b[SH_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = b;
    case (op)
      4'b0000: result = a + b;
      4'b0001: result = a - b;
      4'b0010: result = a << shamt;
      4'b0100: result = WIDTH'(lt_s);
      4'b0110: result = WIDTH'(lt_u);
      4'b1000: result = a ^ b;
      4'b1010: result = a >> shamt;
      4'b1011: result = WIDTH'($signed(a) >>> shamt);
      4'b1100: result = a | b;
      4'b1110: result = a & b;
      default: result = b;
    endcase
  end

  assign zero = ~|result;
endmodule

module exu_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int MEM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [3:0]       in_alu_op,
  input  logic [1:0]       in_src1_sel,
  input  logic [1:0]       in_src2_sel,
  input  logic [2:0]       in_br_type,
  input  logic             in_jalr,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wen,
  input  logic [MEM_W-1:0] in_mem_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [WIDTH-1:0] out_pc,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wen,
  output logic [MEM_W-1:0] out_mem_ctl,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [WIDTH-1:0] imm;
    logic [3:0]       alu_op;
    logic [1:0]       src1_sel;
    logic [1:0]       src2_sel;
    logic [2:0]       br_type;
    logic             jalr;
    logic [RD_W-1:0]  rd;
    logic             wen;
    logic [MEM_W-1:0] mem_ctl;
  } ex_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  ex_t              q;
  ex_t              d;
  logic             full;
  logic             in_fire;
  logic             out_fire;
  logic             taken;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] tgt_base;
  logic [WIDTH-1:0] tgt_sum;

  assign d = '{
    pc:       in_pc,
    rs1:      in_rs1,
    rs2:      in_rs2,
    imm:      in_imm,
    alu_op:   in_alu_op,
    src1_sel: in_src1_sel,
    src2_sel: in_src2_sel,
    br_type:  in_br_type,
    jalr:     in_jalr,
    rd:       in_rd,
    wen:      in_wen,
    mem_ctl:  in_mem_ctl
  };

  assign full = (state == FULL);

  // Select 11 falls back to the register operand.
  always_comb begin
    case (q.src1_sel)
      2'b01:   src1 = q.pc;
      2'b10:   src1 = '0;
      default: src1 = q.rs1;
    endcase
    case (q.src2_sel)
      2'b01:   src2 = q.imm;
      2'b10:   src2 = WIDTH'(4);
      default: src2 = q.rs2;
    endcase
  end

  exu_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (q.alu_op),
    .a      (src1),
    .b      (src2),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Compares reuse the ALU: sub for eq/ne, slt/sltu for the rest.
  always_comb begin
    taken = 1'b0;
    case (q.br_type)
      3'b001:  taken = alu_zero;
      3'b010:  taken = ~alu_zero;
      3'b011:  taken = alu_res[0];
      3'b100:  taken = ~alu_res[0];
      3'b101:  taken = alu_res[0];
      3'b110:  taken = ~alu_res[0];
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    taken = taken & full;
  end

  assign tgt_base = q.jalr ? q.rs1 : q.pc;
  assign tgt_sum  = tgt_base + q.imm;

  // A held taken branch blocks intake so no wrong-path op is latched.
  assign in_ready = (~full | out_ready) & ~flush & ~taken;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = full & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      q     <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (in_fire) begin
      state <= FULL;
      q     <= d;
    end else if (out_fire) begin
      state <= EMPTY;
    end
  end

  assign out_valid      = full;
  assign out_result     = alu_res;
  assign out_store_data = q.rs2;
  assign out_pc         = q.pc;
  assign out_rd         = q.rd;
  assign out_wen        = q.wen;
  assign out_mem_ctl    = q.mem_ctl;

  assign redirect_valid = out_fire & taken;
  assign redirect_pc    = {tgt_sum[WIDTH-1:1],
                           tgt_sum[0] & ~q.jalr};
endmodule

// File: tb/tb_exu_stage.sv
// Testbench for exu_stage: scoreboard of expected LSU outputs
// plus directed scenario tasks.

module tb_exu_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic [3:0]  in_alu_op = '0;
  logic [1:0]  in_src1_sel = '0;
  logic [1:0]  in_src2_sel = '0;
  logic [2:0]  in_br_type = '0;
  logic        in_jalr = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic [3:0]  in_mem_ctl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [3:0]  out_mem_ctl;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  exu_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_alu_op      (in_alu_op),
    .in_src1_sel    (in_src1_sel),
    .in_src2_sel    (in_src2_sel),
    .in_br_type     (in_br_type),
    .in_jalr        (in_jalr),
    .in_rd          (in_rd),
    .in_wen         (in_wen),
    .in_mem_ctl     (in_mem_ctl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_pc         (out_pc),
    .out_rd         (out_rd),
    .out_wen        (out_wen),
    .out_mem_ctl    (out_mem_ctl),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  op;
    logic [1:0]  s1, s2;
    logic [2:0]  br;
    logic        jalr;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  mem;
  } instr_t;

  typedef struct {
    logic [31:0] res, sd, pc, tgt;
    logic [4:0]  rd;
    logic        wen, taken;
    logic [3:0]  mem;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int total = 0;
  int bad = 0;

  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic [31:0] a, b, base;
    logic [4:0]  sh;
    a = (i.s1 == 2'd1) ? i.pc : (i.s1 == 2'd2) ? 32'd0 : i.rs1;
    b = (i.s2 == 2'd1) ? i.imm : (i.s2 == 2'd2) ? 32'd4 : i.rs2;
    sh = b[4:0];
    if (i.op == 4'h0) e.res = a + b;
    else if (i.op == 4'h1) e.res = a - b;
    else if (i.op == 4'h2) e.res = a << sh;
    else if (i.op == 4'h4) e.res = {31'd0, $signed(a) < $signed(b)};
    else if (i.op == 4'h6) e.res = {31'd0, a < b};
    else if (i.op == 4'h8) e.res = a ^ b;
    else if (i.op == 4'hA) e.res = a >> sh;
    else if (i.op == 4'hB) e.res = $unsigned($signed(a) >>> sh);
    else if (i.op == 4'hC) e.res = a | b;
    else if (i.op == 4'hE) e.res = a & b;
    else e.res = b;
    e.taken = (i.br == 3'd1 && a == b)
           || (i.br == 3'd2 && a != b)
           || (i.br == 3'd3 && $signed(a) < $signed(b))
           || (i.br == 3'd4 && $signed(a) >= $signed(b))
           || (i.br == 3'd5 && a < b)
           || (i.br == 3'd6 && a >= b)
           || (i.br == 3'd7);
    base = i.jalr ? i.rs1 : i.pc;
    e.tgt = base + i.imm;
    if (i.jalr) e.tgt[0] = 1'b0;
    e.sd = i.rs2;
    e.pc = i.pc;
    e.rd = i.rd;
    e.wen = i.wen;
    e.mem = i.mem;
    return e;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, rs1, rs2, imm,
                                input logic [3:0] op,
                                input logic [1:0] s1, s2,
                                input logic [2:0] br,
                                input logic jalr);
    instr_t i;
    i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    i.op = op; i.s1 = s1; i.s2 = s2; i.br = br; i.jalr = jalr;
    i.rd = 5'($urandom_range(0, 31));
    i.wen = 1'($urandom_range(0, 1));
    i.mem = 4'($urandom_range(0, 15));
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [3:0] ops [11];
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h8,
            4'hA, 4'hB, 4'hC, 4'hE, 4'h3};
    i = mk($urandom, $urandom, $urandom, $urandom,
           ops[$urandom_range(0, 10)],
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 3) == 0) i.rs2 = i.rs1;
    if (i.br == 3'd1 || i.br == 3'd2) i.op = 4'h1;
    if (i.br == 3'd3 || i.br == 3'd4) i.op = 4'h4;
    if (i.br == 3'd5 || i.br == 3'd6) i.op = 4'h6;
    return i;
  endfunction

  // Presents one instruction and waits (bounded) for the stage to take it.
  task automatic issue(input instr_t i);
    bit ok;
    ok = 1'b0;
    in_pc = i.pc; in_rs1 = i.rs1; in_rs2 = i.rs2; in_imm = i.imm;
    in_alu_op = i.op; in_src1_sel = i.s1; in_src2_sel = i.s2;
    in_br_type = i.br; in_jalr = i.jalr; in_rd = i.rd;
    in_wen = i.wen; in_mem_ctl = i.mem;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(i));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL issue_timeout pc=%h never accepted", i.pc);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sbq.size() != 0; c++) @(posedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d left want=0", sbq.size());
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fire pc=%h", out_pc);
      end else begin
        me = sbq.pop_front();
        if (out_result !== me.res || out_store_data !== me.sd ||
            out_pc !== me.pc || out_rd !== me.rd ||
            out_wen !== me.wen || out_mem_ctl !== me.mem) begin
          bad++;
          $display("FAIL lsu_out pc=%h res=%h/%h sd=%h/%h rd=%h/%h wen=%b/%b mem=%h/%h",
                   me.pc, out_result, me.res, out_store_data, me.sd,
                   out_rd, me.rd, out_wen, me.wen, out_mem_ctl, me.mem);
        end
        total++;
        if (redirect_valid !== me.taken ||
            (me.taken && redirect_pc !== me.tgt)) begin
          bad++;
          $display("FAIL redirect pc=%h got=%b/%h want=%b/%h", me.pc,
                   redirect_valid, redirect_pc, me.taken, me.tgt);
        end
      end
    end
  end

  task automatic test_reset();
    instr_t i;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b%b want=00", out_valid, redirect_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    out_ready = 1'b0;
    i = mk(32'h100, 32'h5, 32'h5, 32'h0, 4'h1, 2'd0, 2'd0, 3'd1, 1'b0);
    @(posedge clk); #1;
    issue(i);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_full got=%b want=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0 ||
        out_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_async got=%b%b pc=%h want=00 pc=0",
               out_valid, redirect_valid, out_pc);
    end
    sbq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b%b want=10", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(mk(32'h0, 32'h7FFFFFFF, 32'h1, 32'h0,
             4'h0, 2'd0, 2'd0, 3'd0, 1'b0));
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'h80000000 ||
        redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL add got=%b %h %b want=1 80000000 0",
               out_valid, out_result, redirect_valid);
    end
    @(posedge clk); #1;
    issue(mk(32'h4, 32'h1234, 32'h1234, 32'h0,
             4'h1, 2'd0, 2'd0, 3'd0, 1'b0));
    @(negedge clk);
    total++;
    if (out_result !== 32'h0) begin
      bad++;
      $display("FAIL sub got=%h want=0", out_result);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(mk(32'h10, 32'd10, 32'd3, 32'h0, 4'h1, 2'd0, 2'd0, 3'd0, 1'b0));
    fork
      begin
        issue(mk(32'h14, 32'd7, 32'd8, 32'h0,
                 4'hC, 2'd0, 2'd0, 3'd0, 1'b0));
        issue(mk(32'h18, 32'hF0, 32'h0, 32'h3,
                 4'h2, 2'd0, 2'd1, 3'd0, 1'b0));
      end
      begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
              out_result !== 32'd7 || out_pc !== 32'h10) begin
            bad++;
            $display("FAIL stall_%0d got=%b%b %h %h want=10 7 10",
                     c, out_valid, in_ready, out_result, out_pc);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    issue(mk(32'h80000010, 32'd5, 32'd5, 32'hFFFFFFF0,
             4'h1, 2'd0, 2'd0, 3'd1, 1'b0));
    in_pc = 32'h80000014;
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000000 ||
        in_ready !== 1'b0) begin
      bad++;
      $display("FAIL beq got=%b %h rdy=%b want=1 80000000 0",
               redirect_valid, redirect_pc, in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL beq_once got=%b%b want=00", redirect_valid, out_valid);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_blt_bltu();
    out_ready = 1'b1;
    issue(mk(32'h200, 32'hFFFFFFFF, 32'h1, 32'h40,
             4'h6, 2'd0, 2'd0, 3'd5, 1'b0));
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL bltu got=%b want=0", redirect_valid);
    end
    @(posedge clk); #1;
    issue(mk(32'h204, 32'hFFFFFFFF, 32'h1, 32'h40,
             4'h4, 2'd0, 2'd0, 3'd3, 1'b0));
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h244) begin
      bad++;
      $display("FAIL blt got=%b %h want=1 244", redirect_valid, redirect_pc);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_jumps();
    instr_t i;
    out_ready = 1'b1;
    i = mk(32'h80000020, 32'h80000103, 32'h0, 32'h4,
           4'h0, 2'd1, 2'd2, 3'd7, 1'b1);
    i.wen = 1'b1;
    issue(i);
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000106 ||
        out_result !== 32'h80000024 || out_wen !== 1'b1) begin
      bad++;
      $display("FAIL jalr got=%b %h %h wen=%b want=1 80000106 80000024 1",
               redirect_valid, redirect_pc, out_result, out_wen);
    end
    @(posedge clk); #1;
    issue(mk(32'hFFFFFFFC, 32'h0, 32'h0, 32'h8,
             4'h0, 2'd1, 2'd2, 3'd7, 1'b0));
    @(negedge clk);
    total++;
    if (out_result !== 32'h0 || redirect_pc !== 32'h4) begin
      bad++;
      $display("FAIL jal_wrap got=%h %h want=0 4", out_result, redirect_pc);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    issue(mk(32'h300, 32'd1, 32'd1, 32'h10,
             4'h1, 2'd0, 2'd0, 3'd1, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got=%b%b want=00", redirect_valid, in_ready);
    end
    void'(sbq.pop_back());
    @(posedge clk); #1 flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty got=%b%b want=00", out_valid, redirect_valid);
    end
    @(posedge clk); #1;
    issue(mk(32'h400, 32'h0, 32'h0, 32'h20,
             4'h0, 2'd1, 2'd2, 3'd7, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h420) begin
      bad++;
      $display("FAIL flush_fire got=%b %h want=1 420",
               redirect_valid, redirect_pc);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_fire_empty got=%b want=0", out_valid);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) issue(rand_instr());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_beq();
    test_blt_bltu();
    test_jumps();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
